// File: rtl/roz_addr_gen.sv
// Rotation/zoom tilemap address generator: line and pixel fixed-point accumulators
// with window and out-of-bounds gating, and shadowed start/increment registers.
module roz_addr_gen #(
    parameter int COORD_W = 13,
    parameter int FRAC_W  = 8,
    parameter int CNT_W   = 9
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [3:0]         A,
    input  logic [15:0]        D,
    input  logic               NWCS,
    input  logic               HSYNC,
    input  logic               VSYNC,
    output logic [COORD_W-1:0] X,
    output logic [COORD_W-1:0] Y,
    output logic               NOB
);

    localparam int ACC_W = COORD_W + FRAC_W;
    typedef logic [ACC_W-1:0] acc_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Start registers hold an integer coordinate; the fraction starts at zero.
    function automatic acc_t to_start(input logic [15:0] r);
        return acc_t'(r[COORD_W-1:0]) << FRAC_W;
    endfunction

    function automatic acc_t to_inc(input logic [15:0] r);
        return acc_t'($signed(r));
    endfunction

    function automatic logic oob(input logic [COORD_W-1:0] v, input logic [4:0] lim,
                                 input logic sgn);
        logic [COORD_W-1:0]        hi_u;
        logic signed [COORD_W-1:0] hi_s;
        hi_u = v >> lim;
        hi_s = $signed(v) >>> lim;
        if (int'(lim) >= COORD_W)
            return 1'b0;
        // Signed range holds when everything from bit LIM up is a copy of the sign.
        if (sgn)
            return !((hi_s == '0) || (hi_s == '1));
        return hi_u != '0;
    endfunction

    logic [5:0][15:0] live;
    logic [5:0][15:0] shdw;
    logic [4:0]       x_lim, y_lim;
    logic             enable, win_en, win_inv, shadow_on, sgn_oob;
    cnt_t             x_min, x_max, y_min, y_max, h_rel, v_rel;

    logic hs_q, vs_q;
    logic hrise, vrise;
    logic wr;

    acc_t xl, yl, xp, yp;
    acc_t xl_nxt, yl_nxt;
    acc_t x_start, y_start;
    cnt_t hcnt, vcnt;

    logic [COORD_W-1:0] x_int, y_int;
    logic               in_win, visible, x_oob, y_oob;

    assign hrise = HSYNC & ~hs_q;
    assign vrise = VSYNC & ~vs_q;
    assign wr    = ~NWCS;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hs_q <= 1'b0;
            vs_q <= 1'b0;
        end else begin
            hs_q <= HSYNC;
            vs_q <= VSYNC;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            live      <= '0;
            shdw      <= '0;
            x_lim     <= '0;
            y_lim     <= '0;
            enable    <= 1'b0;
            win_en    <= 1'b0;
            win_inv   <= 1'b0;
            shadow_on <= 1'b0;
            sgn_oob   <= 1'b0;
            x_min     <= '0;
            x_max     <= '0;
            y_min     <= '0;
            y_max     <= '0;
            h_rel     <= '0;
            v_rel     <= '0;
        end else begin
            // Swap takes the pre-write shadow; a coincident write stays in the shadow.
            if (vrise && shadow_on)
                live <= shdw;
            if (wr) begin
                if (A < 4'd6) begin
                    shdw[A[2:0]] <= D;
                    if (!shadow_on)
                        live[A[2:0]] <= D;
                end
                case (A)
                    4'd6: begin
                        x_lim <= D[4:0];
                        y_lim <= D[12:8];
                    end
                    4'd7: begin
                        enable    <= D[0];
                        win_en    <= D[1];
                        win_inv   <= D[2];
                        shadow_on <= D[3];
                        sgn_oob   <= D[4];
                    end
                    4'd8:  x_min <= D[CNT_W-1:0];
                    4'd9:  x_max <= D[CNT_W-1:0];
                    4'd10: y_min <= D[CNT_W-1:0];
                    4'd11: y_max <= D[CNT_W-1:0];
                    4'd12: h_rel <= D[CNT_W-1:0];
                    4'd13: v_rel <= D[CNT_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Frame start uses the values the live copy is about to take.
    assign x_start = to_start(shadow_on ? shdw[0] : live[0]);
    assign y_start = to_start(shadow_on ? shdw[1] : live[1]);
    assign xl_nxt  = xl + to_inc(live[2]);
    assign yl_nxt  = yl + to_inc(live[3]);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            xl   <= '0;
            yl   <= '0;
            xp   <= '0;
            yp   <= '0;
            hcnt <= '0;
            vcnt <= '0;
        end else if (vrise) begin
            xl   <= x_start;
            yl   <= y_start;
            xp   <= x_start;
            yp   <= y_start;
            vcnt <= v_rel;
            hcnt <= h_rel;
        end else if (hrise) begin
            xl   <= xl_nxt;
            yl   <= yl_nxt;
            xp   <= xl_nxt;
            yp   <= yl_nxt;
            vcnt <= vcnt + cnt_t'(1);
        end else if (HSYNC) begin
            hcnt <= h_rel;
        end else begin
            xp   <= xp + to_inc(live[4]);
            yp   <= yp + to_inc(live[5]);
            hcnt <= hcnt + cnt_t'(1);
        end
    end

    assign x_int   = xp[ACC_W-1:FRAC_W];
    assign y_int   = yp[ACC_W-1:FRAC_W];
    assign x_oob   = oob(x_int, x_lim, sgn_oob);
    assign y_oob   = oob(y_int, y_lim, sgn_oob);
    assign in_win  = (hcnt >= x_min) && (hcnt <= x_max) && (vcnt >= y_min) && (vcnt <= y_max);
    assign visible = win_en ? (in_win ^ win_inv) : 1'b1;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            X   <= '0;
            Y   <= '0;
            NOB <= 1'b1;
        end else begin
            X   <= x_int;
            Y   <= y_int;
            NOB <= ~(enable & visible & ~x_oob & ~y_oob);
        end
    end

endmodule

// File: tb/tb_roz_addr_gen.sv
// Directed bench for roz_addr_gen: integer-arithmetic reference model compared every
// cycle, plus hand-computed spot checks on recorded scan lines.
`timescale 1ns/1ps
module tb_roz_addr_gen;

    localparam int CW = 13;
    localparam int FW = 8;
    localparam int NW = 9;
    localparam int AW = CW + FW;
    localparam int AM = (1 << AW) - 1;
    localparam int CM = (1 << CW) - 1;
    localparam int NM = (1 << NW) - 1;

    logic          CLK, RESET, NWCS, HSYNC, VSYNC;
    logic [3:0]    A;
    logic [15:0]   D;
    logic [CW-1:0] X, Y;
    logic          NOB;

    roz_addr_gen #(.COORD_W(CW), .FRAC_W(FW), .CNT_W(NW)) dut (
        .CLK(CLK), .RESET(RESET), .A(A), .D(D), .NWCS(NWCS),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .X(X), .Y(Y), .NOB(NOB)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;
    bit cmp_en = 0;

    // ---------------- reference model ----------------
    int rg [0:15];
    int sh [0:5];
    int xl = 0, yl = 0, xp = 0, yp = 0, hc = 0, vc = 0;
    bit m_vs = 0, m_hs = 0;
    int mx = 0, my = 0;
    bit mnob = 1;

    function automatic int start_of(int v);
        return (v & CM) << FW;
    endfunction

    function automatic int inc_of(int v);
        return ((v >= 32768) ? v - 65536 : v) & AM;
    endfunction

    function automatic bit m_oob(int v, int lim, bit sgn);
        int s;
        if (lim >= CW) return 0;
        if (!sgn) return v >= (1 << lim);
        s = (v >= (1 << (CW - 1))) ? v - (1 << CW) : v;
        return (s < -(1 << lim)) || (s > (1 << lim) - 1);
    endfunction

    always @(posedge CLK or posedge RESET) begin : model
        int xi, yi;
        bit vr, hr, shd, inw, vis;
        if (RESET) begin
            for (int i = 0; i < 16; i++) rg[i] = 0;
            for (int i = 0; i < 6; i++) sh[i] = 0;
            xl = 0; yl = 0; xp = 0; yp = 0; hc = 0; vc = 0;
            m_vs = 0; m_hs = 0; mx = 0; my = 0; mnob = 1;
        end else begin
            xi = (xp >> FW) & CM;
            yi = (yp >> FW) & CM;
            inw = (hc >= (rg[8] & NM)) && (hc <= (rg[9] & NM)) &&
                  (vc >= (rg[10] & NM)) && (vc <= (rg[11] & NM));
            vis = ((rg[7] >> 1) & 1) ? (inw ^ ((rg[7] >> 2) & 1)) : 1'b1;
            mx = xi;
            my = yi;
            mnob = !((rg[7] & 1) && vis && !m_oob(xi, rg[6] & 31, (rg[7] >> 4) & 1) &&
                     !m_oob(yi, (rg[6] >> 8) & 31, (rg[7] >> 4) & 1));
            vr  = VSYNC && !m_vs;
            hr  = HSYNC && !m_hs;
            shd = (rg[7] >> 3) & 1;
            if (vr) begin
                if (shd) for (int i = 0; i < 6; i++) rg[i] = sh[i];
                xl = start_of(rg[0]); yl = start_of(rg[1]);
                xp = xl; yp = yl;
                vc = rg[13] & NM; hc = rg[12] & NM;
            end else if (hr) begin
                xl = (xl + inc_of(rg[2])) & AM;
                yl = (yl + inc_of(rg[3])) & AM;
                xp = xl; yp = yl;
                vc = (vc + 1) & NM;
            end else if (HSYNC) begin
                hc = rg[12] & NM;
            end else begin
                xp = (xp + inc_of(rg[4])) & AM;
                yp = (yp + inc_of(rg[5])) & AM;
                hc = (hc + 1) & NM;
            end
            if (!NWCS) begin
                if (A < 6) begin
                    sh[A] = D;
                    if (!shd) rg[A] = D;
                end else if (A < 14) begin
                    rg[A] = D;
                end
            end
            m_vs = VSYNC;
            m_hs = HSYNC;
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            n_chk++;
            if (int'(X) != mx || int'(Y) != my || NOB != mnob) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t: X=%0d Y=%0d NOB=%0b expected X=%0d Y=%0d NOB=%0b",
                         $time, X, Y, NOB, mx, my, mnob);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [CW-1:0] xr [0:319];
    logic [CW-1:0] yr [0:319];
    logic          nr [0:319];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input int a, input int d);
        @(negedge CLK);
        A = a[3:0]; D = d[15:0]; NWCS = 1'b0;
        @(negedge CLK);
        NWCS = 1'b1;
    endtask

    task automatic vsync_pulse();
        @(negedge CLK);
        VSYNC = 1'b1;
        repeat (2) @(negedge CLK);
        VSYNC = 1'b0;
    endtask

    // HSYNC high for 4 cycles (optionally with VSYNC rising alongside), then n low cycles recorded.
    task automatic line(input int n, input bit with_vs);
        @(negedge CLK);
        HSYNC = 1'b1;
        if (with_vs) VSYNC = 1'b1;
        repeat (4) @(negedge CLK);
        HSYNC = 1'b0;
        VSYNC = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            xr[i] = X; yr[i] = Y; nr[i] = NOB;
        end
    endtask

    initial begin
        RESET = 1'b1; A = '0; D = '0; NWCS = 1'b1; HSYNC = 1'b0; VSYNC = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_x", X, 0);
        chk("reset_y", Y, 0);
        chk("reset_nob", NOB, 1);
        cmp_en = 1;
        RESET = 1'b0;

        // Basic scan
        wr(6, 16'h1F1F); wr(4, 16'h0400); wr(3, 16'h0100); wr(7, 16'h0001);
        vsync_pulse();
        line(60, 0);
        chk("scan_x0", xr[0], 0);
        chk("scan_x1", xr[1], 4);
        chk("scan_x2", xr[2], 8);
        chk("scan_x3", xr[3], 12);
        chk("scan_y_line1", yr[10], 1);
        chk("scan_nob", nr[30], 0);
        line(60, 0);
        chk("scan_y_line2", yr[10], 2);

        // Window
        wr(8, 16'h20); wr(9, 16'h80); wr(10, 5); wr(11, 16'h111); wr(12, 0); wr(13, 0);
        wr(7, 16'h0003);
        vsync_pulse();
        for (int l = 1; l <= 4; l++) line(140, 0);
        chk("win_line4_nob", nr[64], 1);
        line(140, 0);
        chk("win_h31", nr[31], 1);
        chk("win_h32", nr[32], 0);
        chk("win_h128", nr[128], 0);
        chk("win_h129", nr[129], 1);
        wr(7, 16'h0007);
        line(140, 0);
        chk("wininv_h31", nr[31], 0);
        chk("wininv_h32", nr[32], 1);
        chk("wininv_h128", nr[128], 1);
        chk("wininv_h129", nr[129], 0);

        // Unsigned OOB
        wr(7, 16'h0001); wr(6, 16'h1F08); wr(4, 16'h0100);
        vsync_pulse();
        line(300, 0);
        chk("oobu_x255", xr[255], 255);
        chk("oobu_nob255", nr[255], 0);
        chk("oobu_x256", xr[256], 256);
        chk("oobu_nob256", nr[256], 1);

        // Signed OOB
        wr(7, 16'h0011); wr(0, 16'hFED4);
        vsync_pulse();
        line(60, 0);
        chk("oobs_x0", xr[0], 13'h1ED4);
        chk("oobs_nob43", nr[43], 1);
        chk("oobs_x44", xr[44], 13'h1F00);
        chk("oobs_nob44", nr[44], 0);

        // Shadow
        wr(6, 16'h1F1F); wr(7, 16'h0009);
        vsync_pulse();
        line(10, 0);
        chk("shd_before", xr[0], 13'h1ED4);
        wr(0, 100);
        line(10, 0);
        chk("shd_same_frame", xr[0], 13'h1ED4);
        vsync_pulse();
        line(10, 0);
        chk("shd_after_vs", xr[0], 100);
        wr(7, 16'h0001); wr(0, 200);
        line(10, 0);
        chk("noshd_same_frame", xr[0], 100);
        vsync_pulse();
        line(10, 0);
        chk("noshd_after_vs", xr[0], 200);

        // Wrap and coincident syncs
        wr(0, 16'h1FFF);
        vsync_pulse();
        line(10, 0);
        chk("wrap_x0", xr[0], 8191);
        chk("wrap_x1", xr[1], 0);
        chk("wrap_x2", xr[2], 1);
        chk("wrap_nob", int'(nr[0]) + int'(nr[1]) + int'(nr[2]), 0);
        wr(1, 7);
        line(10, 1);
        chk("coinc_x0", xr[0], 8191);
        chk("coinc_y0", yr[0], 7);

        // Mid-line async reset
        wr(0, 0);
        vsync_pulse();
        @(negedge CLK);
        HSYNC = 1'b1;
        repeat (2) @(negedge CLK);
        HSYNC = 1'b0;
        repeat (10) @(negedge CLK);
        chk("pre_reset_x", X, 9);
        #2 RESET = 1'b1;
        #1;
        chk("async_reset_x", X, 0);
        chk("async_reset_y", Y, 0);
        chk("async_reset_nob", NOB, 1);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        vsync_pulse();
        line(10, 0);
        chk("post_reset_nob", nr[5], 1);
        chk("post_reset_x", xr[5], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
